// File: rtl/param_regfile.sv
// Parametrised 1W/2R register file: optional hard-wired zero register,
// write-to-read forwarding, and combinational or registered read ports.
module param_regfile #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit REG_READ = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata0,
  output logic [WIDTH-1:0]  rdata1
);

  localparam int NPORT = 2;
  // One extra bit so DEPTH itself is representable for the range compare.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0]  mem;
  logic [NPORT-1:0][ADDR_W-1:0] ra;
  logic [NPORT-1:0][WIDTH-1:0]  rd;
  logic                         wr_ok;

  assign ra = {raddr1, raddr0};

  // A legal write also gates the bypass path, so reset and illegal
  // addresses can never leak wdata onto a read port.
  assign wr_ok = we && !rst && ({1'b0, waddr} < DEPTH_C) &&
                 !(ZERO_REG && (waddr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        mem        <= '0;
    else if (wr_ok) mem[waddr] <= wdata;
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic [WIDTH-1:0] rv;

    always_comb begin
      rv = '0;
      if (({1'b0, ra[p]} < DEPTH_C) && !(ZERO_REG && (ra[p] == '0))) begin
        if (BYPASS && wr_ok && (waddr == ra[p])) rv = wdata;
        else                                      rv = mem[ra[p]];
      end
    end

    if (REG_READ) begin : g_reg
      logic [WIDTH-1:0] q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= rv;
      end
      assign rd[p] = q;
    end else begin : g_comb
      assign rd[p] = rv;
    end
  end

  assign rdata0 = rd[0];
  assign rdata1 = rd[1];

endmodule
